// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter with round-robin tie-break, beat-limited tenure,
// and combinational address/data muxing toward the shared slave bus.
module ahb_arbiter #(
  parameter int MAX_BEATS = 8
) (
  input  logic        HCLK,
  input  logic        HRESTn,
  input  logic        HBUSREQ_M0,
  input  logic        HBUSREQ_M1,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic        HBURST_M0,
  input  logic        HBURST_M1,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HWDATA_M1,
  input  logic        HREADY,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic        HBURST,
  output logic [31:0] HWDATA,
  output logic        HGRANT_M0,
  output logic        HGRANT_M1,
  output logic [1:0]  HMASTER,
  output logic [1:0]  HMASTER_D
);

  localparam logic [3:0] MAXB = 4'(MAX_BEATS);

  // Encoding doubles as the HMASTER value.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // 1: M1 was granted most recently
  logic        first_q, first_d;
  logic [3:0]  beat_q, beat_d;
  logic [1:0]  hmd_q, hmd_d;
  logic        own_req, oth_req, arb_pt, gnt_chg;
  logic [1:0]  trans_sel;

  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    if (state_q == OWN0) begin
      own_req = HBUSREQ_M0;
      oth_req = HBUSREQ_M1;
    end else if (state_q == OWN1) begin
      own_req = HBUSREQ_M1;
      oth_req = HBUSREQ_M0;
    end
    arb_pt = HREADY && ((state_q == NONE) || !own_req || ((beat_q == MAXB) && oth_req));

    state_d = state_q;
    if (arb_pt) begin
      if (HBUSREQ_M0 && HBUSREQ_M1) state_d = last_q ? OWN0 : OWN1;
      else if (HBUSREQ_M0)          state_d = OWN0;
      else if (HBUSREQ_M1)          state_d = OWN1;
      else                          state_d = NONE;
    end
    gnt_chg = (state_d != state_q);

    last_d = last_q;
    if (state_d == OWN0)      last_d = 1'b0;
    else if (state_d == OWN1) last_d = 1'b1;

    // A handover cycle must not carry a SEQ beat, so remember it until accepted.
    if (gnt_chg)     first_d = (state_d != NONE);
    else if (HREADY) first_d = 1'b0;
    else             first_d = first_q;

    beat_d = beat_q;
    if (gnt_chg)                                  beat_d = 4'd0;
    else if (HREADY && HTRANS[1] && beat_q < MAXB) beat_d = beat_q + 4'd1;

    hmd_d = HREADY ? HMASTER : hmd_q;
  end

  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      state_q <= NONE;
      last_q  <= 1'b1;
      first_q <= 1'b0;
      beat_q  <= 4'd0;
      hmd_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      first_q <= first_d;
      beat_q  <= beat_d;
      hmd_q   <= hmd_d;
    end
  end

  assign HGRANT_M0 = (state_q == OWN0);
  assign HGRANT_M1 = (state_q == OWN1);
  assign HMASTER   = state_q;
  assign HMASTER_D = hmd_q;

  always_comb begin
    trans_sel = 2'b00;
    HADDR     = 32'd0;
    HWRITE    = 1'b0;
    HSIZE     = 3'd0;
    HBURST    = 1'b0;
    case (state_q)
      OWN0: begin
        trans_sel = HTRANS_M0;
        HADDR     = HADDR_M0;
        HWRITE    = HWRITE_M0;
        HSIZE     = HSIZE_M0;
        HBURST    = HBURST_M0;
      end
      OWN1: begin
        trans_sel = HTRANS_M1;
        HADDR     = HADDR_M1;
        HWRITE    = HWRITE_M1;
        HSIZE     = HSIZE_M1;
        HBURST    = HBURST_M1;
      end
      default: ;
    endcase
    HTRANS = (first_q && trans_sel == 2'b11) ? 2'b00 : trans_sel;
  end

  always_comb begin
    case (hmd_q)
      2'b01:   HWDATA = HWDATA_M0;
      2'b10:   HWDATA = HWDATA_M1;
      default: HWDATA = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: table-driven arbitration sequence plus
// hand-written burst-limit, wait-state, SEQ-handover and async-reset cases.
module tb_ahb_arbiter;

  localparam logic [31:0] A0  = 32'h0000_0004;
  localparam logic [31:0] A1  = 32'h0000_0100;
  localparam logic [31:0] WD0 = 32'hA0A0_0001;
  localparam logic [31:0] WD1 = 32'hB1B1_0002;

  logic        HCLK = 1'b0;
  logic        HRESTn;
  logic        HBUSREQ_M0, HBUSREQ_M1;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic [31:0] HADDR_M0, HADDR_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1;
  logic        HBURST_M0, HBURST_M1;
  logic [31:0] HWDATA_M0, HWDATA_M1;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HBURST;
  logic [31:0] HWDATA;
  logic        HGRANT_M0, HGRANT_M1;
  logic [1:0]  HMASTER, HMASTER_D;

  ahb_arbiter #(.MAX_BEATS(8)) dut (
    .HCLK(HCLK), .HRESTn(HRESTn),
    .HBUSREQ_M0(HBUSREQ_M0), .HBUSREQ_M1(HBUSREQ_M1),
    .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
    .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
    .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
    .HBURST_M0(HBURST_M0), .HBURST_M1(HBURST_M1),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
    .HREADY(HREADY),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA),
    .HGRANT_M0(HGRANT_M0), .HGRANT_M1(HGRANT_M1),
    .HMASTER(HMASTER), .HMASTER_D(HMASTER_D)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        r0, r1;
    logic [1:0]  t0, t1;
    logic        rdy;
    logic        g0, g1;
    logic [1:0]  hm, hmd, tr;
    logic [31:0] ad;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd_of(input logic [1:0] hmd);
    case (hmd)
      2'b01:   return WD0;
      2'b10:   return WD1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    HBUSREQ_M0 = 1'b0; HBUSREQ_M1 = 1'b0;
    HTRANS_M0 = 2'b00; HTRANS_M1 = 2'b00;
    HADDR_M0 = A0; HADDR_M1 = A1;
    HWRITE_M0 = 1'b1; HWRITE_M1 = 1'b0;
    HSIZE_M0 = 3'd2; HSIZE_M1 = 3'd1;
    HBURST_M0 = 1'b1; HBURST_M1 = 1'b0;
    HWDATA_M0 = WD0; HWDATA_M1 = WD1;
    HREADY = 1'b1;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".g0"}, 32'(HGRANT_M0), 32'd0);
    chk({tag, ".g1"}, 32'(HGRANT_M1), 32'd0);
    chk({tag, ".hm"}, 32'(HMASTER), 32'd0);
    chk({tag, ".hmd"}, 32'(HMASTER_D), 32'd0);
    chk({tag, ".tr"}, 32'(HTRANS), 32'd0);
    chk({tag, ".ad"}, HADDR, 32'd0);
    chk({tag, ".ctl"}, {27'd0, HWRITE, HSIZE, HBURST}, 32'd0);
    chk({tag, ".wd"}, HWDATA, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge HCLK);
    HRESTn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESTn = 1'b1;
  endtask

  initial begin
    // NONSEQ grant, hold, handover on drop, idle, round-robin in both directions.
    //            r0 r1 t0     t1     rdy g0 g1 hm     hmd    tr     ad
    tbl[0] = '{1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10, A0};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, A0};
    tbl[2] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, A0};
    tbl[3] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00, A1};
    tbl[4] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, A1};
    tbl[5] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 32'd0};
    tbl[6] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, A0};
    tbl[7] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 32'd0};
    tbl[8] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, A1};
    tbl[9] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, A1};

    idle_inputs();
    HRESTn = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge HCLK);
    HRESTn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      HBUSREQ_M0 = tbl[i].r0; HBUSREQ_M1 = tbl[i].r1;
      HTRANS_M0 = tbl[i].t0;  HTRANS_M1 = tbl[i].t1;
      HREADY = tbl[i].rdy;
      step();
      chk($sformatf("v%0d.g0", i), 32'(HGRANT_M0), 32'(tbl[i].g0));
      chk($sformatf("v%0d.g1", i), 32'(HGRANT_M1), 32'(tbl[i].g1));
      chk($sformatf("v%0d.hm", i), 32'(HMASTER), 32'(tbl[i].hm));
      chk($sformatf("v%0d.hmd", i), 32'(HMASTER_D), 32'(tbl[i].hmd));
      chk($sformatf("v%0d.tr", i), 32'(HTRANS), 32'(tbl[i].tr));
      chk($sformatf("v%0d.ad", i), HADDR, tbl[i].ad);
      chk($sformatf("v%0d.wd", i), HWDATA, wd_of(tbl[i].hmd));
    end

    // Beat limit: M0 bursts with M1 waiting; after beat_cnt reaches 8 the grant moves.
    do_reset();
    HBUSREQ_M0 = 1'b1; HBUSREQ_M1 = 1'b1;
    step();
    chk("burst.own", 32'(HMASTER), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      HTRANS_M0 = (k == 1) ? 2'b10 : 2'b11;
      HADDR_M0 = 32'(4 * k);
      step();
      if (k <= 8) chk($sformatf("burst.k%0d.g0", k), 32'(HGRANT_M0), 32'd1);
      else        chk("burst.handover.g1", 32'(HGRANT_M1), 32'd1);
    end
    chk("burst.handover.g0", 32'(HGRANT_M0), 32'd0);
    HTRANS_M1 = 2'b10;
    step();
    chk("burst.cnt_cleared.g1", 32'(HGRANT_M1), 32'd1);
    chk("burst.m1.hmd", 32'(HMASTER_D), 32'd2);

    // Wait states while the owner drops its request: nothing moves until HREADY.
    do_reset();
    HBUSREQ_M0 = 1'b1;
    step();
    chk("wait.own0", 32'(HMASTER), 32'd1);
    HREADY = 1'b0; HBUSREQ_M0 = 1'b0; HBUSREQ_M1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wait.c%0d.g0", k), 32'(HGRANT_M0), 32'd1);
      chk($sformatf("wait.c%0d.hmd", k), 32'(HMASTER_D), 32'd0);
    end
    HREADY = 1'b1;
    step();
    chk("wait.release.g1", 32'(HGRANT_M1), 32'd1);
    chk("wait.release.hmd", 32'(HMASTER_D), 32'd1);

    // SEQ presented on the first owned cycle is suppressed, then passes.
    do_reset();
    HBUSREQ_M1 = 1'b1; HTRANS_M1 = 2'b11;
    step();
    chk("seq.first.hm", 32'(HMASTER), 32'd2);
    chk("seq.first.tr", 32'(HTRANS), 32'd0);
    step();
    chk("seq.second.tr", 32'(HTRANS), 32'd3);

    // Asynchronous reset mid-burst, then arbitration on the first edge after release.
    do_reset();
    HBUSREQ_M0 = 1'b1;
    step();
    HTRANS_M0 = 2'b10;
    step();
    HTRANS_M0 = 2'b11;
    step();
    chk("midrst.pre.wd", HWDATA, WD0);
    @(negedge HCLK);
    HRESTn = 1'b0;
    #1;
    chk_zero("midrst");
    #3;
    HRESTn = 1'b1;
    HBUSREQ_M1 = 1'b1; HTRANS_M0 = 2'b00;
    step();
    chk("postrst.g0", 32'(HGRANT_M0), 32'd1);
    chk("postrst.g1", 32'(HGRANT_M1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
